// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus arbiter: width defaults, FSM states, slice helper.
package reg_bus_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } arb_state_e;

    // Low bit of element idx inside a packed vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester and peripheral signals of the register-bus arbiter; the arbiter uses the slave view,
// the requesters/peripheral environment uses the master view.
interface reg_bus_arbiter_if
    import reg_bus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic [DATA_W-1:0]      rdata;
    logic [NREQ-1:0]        rvalid;
    logic [ADDR_W-1:0]      address;
    logic [DATA_W-1:0]      data_in;
    logic                   data_write;
    logic [DATA_W-1:0]      data_out;

    modport slave (
        input  req, req_we, req_addr, req_wdata, data_out,
        output gnt, rdata, rvalid, address, data_in, data_write
    );

    modport master (
        output req, req_we, req_addr, req_wdata, data_out,
        input  gnt, rdata, rvalid, address, data_in, data_write
    );

endinterface

// File: rtl/reg_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i, wrapping.
// Requesters flagged in excl_i are skipped for this decision.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [NREQ-1:0]  excl_i,
    output logic [NREQ-1:0]  win_o,
    output logic             any_o
);

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win_c;
    logic            found_c;
    int              idx;

    always_comb begin
        elig    = req_i & ~excl_i;
        win_c   = '0;
        found_c = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found_c && elig[idx]) begin
                win_c[idx] = 1'b1;
                found_c    = 1'b1;
            end
        end
    end

    assign win_o = win_c;
    assign any_o = found_c;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin register-bus arbiter; write strobe+gnt at T+1, read rdata+gnt+rvalid at T+2.
// Backpressure: requesters hold req until their one-cycle gnt; all outputs registered.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    reg_bus_arbiter_if.slave  bus
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              data_write_q, data_write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;

    logic [NREQ-1:0]   pick_win;
    logic              pick_any;
    int                win_idx;

    // A read completing this cycle shows its gnt; that requester may not win again until it drops req.
    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i  (bus.req),
        .ptr_i  (ptr_q),
        .excl_i (gnt_q),
        .win_o  (pick_win),
        .any_o  (pick_any)
    );

    always_comb begin
        win_idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_win[i]) begin
                win_idx = i;
            end
        end

        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        data_write_d = 1'b0;
        rdata_d      = rdata_q;
        gnt_d        = '0;
        rvalid_d     = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d   = pick_win;
                    address_d = bus.req_addr[slice_lo(win_idx, ADDR_W) +: ADDR_W];
                    data_in_d = bus.req_wdata[slice_lo(win_idx, DATA_W) +: DATA_W];
                    ptr_d     = (win_idx == NREQ - 1) ? '0 : PTR_W'(win_idx + 1);
                    if (bus.req_we[win_idx]) begin
                        state_d      = WRITE;
                        data_write_d = 1'b1;
                        gnt_d        = pick_win;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                rdata_d  = bus.data_out;
                gnt_d    = owner_q;
                rvalid_d = owner_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            address_q    <= '0;
            data_in_q    <= '0;
            data_write_q <= 1'b0;
            rdata_q      <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            data_write_q <= data_write_d;
            rdata_q      <= rdata_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.rdata      = rdata_q;
    assign bus.address    = address_q;
    assign bus.data_in    = data_in_q;
    assign bus.data_write = data_write_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: two requesters, a 16-entry peripheral register file and a
// transaction-level reference (round-robin order, access latencies, expected register image).
module tb_reg_bus_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [DATA_W-1:0] periph_mem [0:15];
    logic [DATA_W-1:0] ref_mem    [0:15];
    int                ref_ptr;

    logic              poke_en;
    logic [ADDR_W-1:0] poke_addr;
    logic [DATA_W-1:0] poke_dat;

    logic              cur_we    [NREQ];
    logic [ADDR_W-1:0] cur_addr  [NREQ];
    logic [DATA_W-1:0] cur_wdata [NREQ];

    reg_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Peripheral: combinational read, strobed write; the bench can preload it through poke.
    assign bus.data_out = periph_mem[bus.address];
    always @(posedge clk) begin
        if (poke_en)
            periph_mem[poke_addr] <= poke_dat;
        else if (bus.data_write)
            periph_mem[bus.address] <= bus.data_in;
    end

    function automatic int exp_pick(input logic [NREQ-1:0] r, input int ptr);
        int c;
        for (int i = 0; i < NREQ; i++) begin
            c = (ptr + i) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        poke_addr = a;
        poke_dat  = d;
        poke_en   = 1'b1;
        ref_mem[a] = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic set_req(input int k, input logic on, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req[k]                        = on;
        bus.req_we[k]                     = we;
        bus.req_addr[k*ADDR_W +: ADDR_W]  = a;
        bus.req_wdata[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic new_cmd(input int k, input bit mixed);
        cur_we[k]    = mixed ? 1'($urandom_range(0, 1)) : 1'b1;
        cur_addr[k]  = 4'($urandom_range(0, 15));
        cur_wdata[k] = 8'($urandom);
        set_req(k, 1'b1, cur_we[k], cur_addr[k], cur_wdata[k]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 4'h9, 8'h11);
        set_req(1, 1'b1, 1'b1, 4'hC, 8'h22);
        step();
        step();
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
        vectors++; if (bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00", bus.rvalid); end
        vectors++; if (bus.rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
        vectors++; if (bus.address !== 4'h0) begin miscompares++; $display("FAIL reset_address: got %h want 0", bus.address); end
        vectors++; if (bus.data_in !== 8'h00) begin miscompares++; $display("FAIL reset_data_in: got %h want 00", bus.data_in); end
        vectors++; if (bus.data_write !== 1'b0) begin miscompares++; $display("FAIL reset_data_write: got %b want 0", bus.data_write); end
        rst = 1'b0;
        ref_ptr = 0;
        step();
        vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL reset_first_gnt: got %b want 01", bus.gnt); end
        vectors++; if (bus.address !== 4'h9 || bus.data_in !== 8'h11) begin miscompares++; $display("FAIL reset_first_access: got %h/%h want 9/11", bus.address, bus.data_in); end
        ref_mem[9] = 8'h11;
        ref_ptr = 1;
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        step();
        step();
    endtask

    task automatic test_single_write();
        int extra;
        set_req(0, 1'b1, 1'b1, 4'h3, 8'hA5);
        step();
        vectors++; if (bus.data_write !== 1'b1) begin miscompares++; $display("FAIL wr_strobe: got %b want 1", bus.data_write); end
        vectors++; if (bus.address !== 4'h3) begin miscompares++; $display("FAIL wr_address: got %h want 3", bus.address); end
        vectors++; if (bus.data_in !== 8'hA5) begin miscompares++; $display("FAIL wr_data_in: got %h want a5", bus.data_in); end
        vectors++; if (bus.gnt !== 2'b01 || bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL wr_gnt: got gnt %b rvalid %b want 01/00", bus.gnt, bus.rvalid); end
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        ref_mem[3] = 8'hA5;
        ref_ptr = 1;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.data_write !== 1'b0 || bus.gnt !== 2'b00) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL wr_single_pulse: got %0d extra strobe/gnt cycles want 0", extra); end
    endtask

    task automatic test_single_read();
        poke(4'h7, 8'h5A);
        set_req(1, 1'b1, 1'b0, 4'h7, 8'($urandom));
        step();
        vectors++; if (bus.address !== 4'h7 || bus.data_write !== 1'b0) begin miscompares++; $display("FAIL rd_address: got %h/%b want 7/0", bus.address, bus.data_write); end
        vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL rd_early_gnt: got %b want 00", bus.gnt); end
        step();
        vectors++; if (bus.rdata !== 8'h5A) begin miscompares++; $display("FAIL rd_rdata: got %h want 5a", bus.rdata); end
        vectors++; if (bus.gnt !== 2'b10 || bus.rvalid !== 2'b10) begin miscompares++; $display("FAIL rd_gnt_rvalid: got %b/%b want 10/10", bus.gnt, bus.rvalid); end
        set_req(1, 1'b0, 1'b0, 4'h0, 8'h00);
        ref_ptr = 0;
        step();
        vectors++; if (bus.rvalid !== 2'b00 || bus.rdata !== 8'h5A) begin miscompares++; $display("FAIL rd_hold: got rvalid %b rdata %h want 00/5a", bus.rvalid, bus.rdata); end
        step();
    endtask

    task automatic test_contention(input int n_acc, input bit mixed);
        int               done, since, k, prev_lat, lat, quiet;
        int               cnt [NREQ];
        logic [NREQ-1:0]  exp_oh;
        logic [ADDR_W-1:0] a;
        done = 0; since = 0; prev_lat = 0; quiet = 0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            new_cmd(i, mixed);
        end
        while (done < n_acc) begin
            step();
            since++;
            if (bus.gnt !== 2'b00) begin
                k = exp_pick({NREQ{1'b1}}, ref_ptr);
                exp_oh = '0;
                exp_oh[k] = 1'b1;
                vectors++; if (bus.gnt !== exp_oh) begin miscompares++; $display("FAIL rr_order[%0d]: got %b want %b", done, bus.gnt, exp_oh); end
                a = cur_addr[k];
                lat = cur_we[k] ? 1 : 2;
                if (cur_we[k]) begin
                    vectors++; if (bus.data_write !== 1'b1 || bus.address !== a || bus.data_in !== cur_wdata[k] || bus.rvalid !== 2'b00)
                        begin miscompares++; $display("FAIL rr_write[%0d]: got %b %h %h want 1 %h %h", done, bus.data_write, bus.address, bus.data_in, a, cur_wdata[k]); end
                    ref_mem[a] = cur_wdata[k];
                end else begin
                    vectors++; if (bus.rvalid !== exp_oh || bus.rdata !== ref_mem[a] || bus.data_write !== 1'b0)
                        begin miscompares++; $display("FAIL rr_read[%0d]: got rvalid %b rdata %h want %b %h", done, bus.rvalid, bus.rdata, exp_oh, ref_mem[a]); end
                end
                // Acceptances are 2 cycles apart; a grant lands 1 (write) or 2 (read) cycles after acceptance.
                if (done > 0) begin
                    vectors++; if (since !== 2 + lat - prev_lat) begin miscompares++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", done, since, 2 + lat - prev_lat); end
                end
                prev_lat = lat;
                ref_ptr = (k + 1) % NREQ;
                cnt[k]++;
                done++;
                since = 0;
                if (done >= n_acc - 1) set_req(k, 1'b0, 1'b0, 4'h0, 8'h00);
                else new_cmd(k, mixed);
            end else if (since > 8) begin
                vectors++; miscompares++;
                $display("FAIL rr_timeout: got no gnt in %0d cycles want gnt", since);
                break;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            vectors++; if (cnt[i] !== n_acc / NREQ) begin miscompares++; $display("FAIL rr_fairness[%0d]: got %0d grants want %0d", i, cnt[i], n_acc / NREQ); end
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.gnt !== 2'b00 || bus.data_write !== 1'b0) quiet++;
        end
        vectors++; if (quiet !== 0) begin miscompares++; $display("FAIL rr_quiet: got %0d busy cycles after drain want 0", quiet); end
    endtask

    task automatic test_reset_mid_read();
        logic [ADDR_W-1:0] a;
        int                wait_cyc;
        a = 4'($urandom_range(1, 15));
        set_req(0, 1'b1, 1'b0, a, 8'h00);
        step();
        vectors++; if (bus.address !== a) begin miscompares++; $display("FAIL mid_rd_address: got %h want %h", bus.address, a); end
        rst = 1'b1;
        step();
        vectors++; if (bus.gnt !== 2'b00 || bus.rvalid !== 2'b00) begin miscompares++; $display("FAIL mid_rd_abort: got gnt %b rvalid %b want 00/00", bus.gnt, bus.rvalid); end
        vectors++; if (bus.rdata !== 8'h00 || bus.address !== 4'h0 || bus.data_write !== 1'b0) begin miscompares++; $display("FAIL mid_rd_clear: got %h %h %b want 00 0 0", bus.rdata, bus.address, bus.data_write); end
        rst = 1'b0;
        ref_ptr = 0;
        wait_cyc = 0;
        do begin
            step();
            wait_cyc++;
        end while (bus.gnt === 2'b00 && wait_cyc < 8);
        vectors++; if (wait_cyc !== 2) begin miscompares++; $display("FAIL mid_rd_retry_latency: got %0d want 2", wait_cyc); end
        vectors++; if (bus.gnt !== 2'b01 || bus.rvalid !== 2'b01 || bus.rdata !== ref_mem[a])
            begin miscompares++; $display("FAIL mid_rd_retry: got %b %b %h want 01 01 %h", bus.gnt, bus.rvalid, bus.rdata, ref_mem[a]); end
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        ref_ptr = 1;
        step();
        step();
    endtask

    task automatic test_stability();
        logic [ADDR_W-1:0] a, b;
        logic [DATA_W-1:0] d;
        a = 4'($urandom_range(0, 15));
        b = a ^ 4'h5;
        d = 8'($urandom);
        set_req(0, 1'b1, 1'b1, a, d);
        step();
        vectors++; if (bus.data_write !== 1'b1 || bus.address !== a || bus.data_in !== d) begin miscompares++; $display("FAIL stab_wr: got %b %h %h want 1 %h %h", bus.data_write, bus.address, bus.data_in, a, d); end
        set_req(0, 1'b0, 1'b1, b, ~d);
        ref_mem[a] = d;
        step();
        vectors++; if (bus.address !== a || bus.data_in !== d || bus.data_write !== 1'b0) begin miscompares++; $display("FAIL stab_wr_hold: got %h %h %b want %h %h 0", bus.address, bus.data_in, bus.data_write, a, d); end
        a = 4'($urandom_range(0, 15));
        b = a ^ 4'hA;
        poke(b, ~ref_mem[a]);
        set_req(0, 1'b1, 1'b0, a, 8'h00);
        step();
        set_req(0, 1'b1, 1'b1, b, 8'($urandom));
        vectors++; if (bus.address !== a) begin miscompares++; $display("FAIL stab_rd_addr: got %h want %h", bus.address, a); end
        step();
        vectors++; if (bus.gnt !== 2'b01 || bus.rdata !== ref_mem[a] || bus.address !== a)
            begin miscompares++; $display("FAIL stab_rd: got %b %h %h want 01 %h %h", bus.gnt, bus.rdata, bus.address, ref_mem[a], a); end
        set_req(0, 1'b0, 1'b0, 4'h0, 8'h00);
        step();
        step();
    endtask

    task automatic test_memory_image();
        for (int i = 0; i < 16; i++) begin
            vectors++; if (periph_mem[i] !== ref_mem[i]) begin miscompares++; $display("FAIL mem_image[%0d]: got %h want %h", i, periph_mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        poke_en       = 1'b0;
        poke_addr     = '0;
        poke_dat      = '0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            cur_we[i] = 1'b0; cur_addr[i] = '0; cur_wdata[i] = '0;
        end
        for (int i = 0; i < 16; i++) poke(4'(i), 8'($urandom));
        test_reset();
        test_single_write();
        test_single_read();
        test_contention(8, 1'b0);
        test_contention(16, 1'b1);
        test_reset_mid_read();
        test_stability();
        test_memory_image();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1);
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Shares the single peripheral register port (4-bit address, 8-bit write data, write strobe, 8-bit read data) between several register-bus masters: the SPI register bridge, an on-chip init sequencer and any test master. Each master issues one read or write at a time through a req/gnt handshake. Masters are served round-robin. All peripheral-side signals are registered, so the peripheral sees clean single-cycle strobes.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 4, register address width
- DATA_W, 8, register data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- req  in  NREQ  per-requester access request; held high until gnt
- req_we  in  NREQ  per-requester: 1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed per-requester address; requester i occupies [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed per-requester write data
- gnt  out  NREQ  one-cycle pulse: access completed for that requester
- rdata  out  DATA_W  read data, valid when rvalid
- rvalid  out  NREQ  one-cycle pulse, concurrent with gnt, reads only
- address  out  ADDR_W  to peripheral
- data_in  out  DATA_W  to peripheral write data
- data_write  out  1  to peripheral: one-cycle write strobe
- data_out  in  DATA_W  from peripheral: combinational function of address

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - If any req is set, pick the winner round-robin.
  - Latch the winner's we, addr and wdata into address/data_in. The latched values are frozen for the whole access; later requester changes are ignored.
  - Go to WRITE if we=1, otherwise READ.
  - With no request, stay in IDLE.
- WRITE:
  - data_write=1 and gnt[winner]=1 for exactly this cycle.
  - Return to IDLE.
- READ:
  - data_write=0. Sample data_out into rdata at the end of the cycle.
  - Return to IDLE with gnt[winner]=1 and rvalid[winner]=1 asserted in that IDLE cycle.
  - rdata holds until the next read completes.
- Round-robin rule:
  - A priority pointer names the highest-priority requester.
  - After a grant to requester k, the pointer becomes (k+1) mod NREQ.
  - The search starts at the pointer and wraps through NREQ-1 back to 0.
- A requester must drop req in the cycle after seeing gnt. If req is still high, it is treated as a new request.
- An IDLE cycle that shows a read's gnt/rvalid may also arbitrate the next access. The requester just granted is excluded from that same-cycle decision.
- address/data_in hold their last value between accesses. data_write is 0 outside WRITE.
- Reset, including mid-access:
  - State becomes IDLE; pointer, address, data_in, data_write, rdata, gnt and rvalid all become 0.
  - An in-flight access is aborted: no gnt and no second data_write.
  - A write whose strobe was already issued has taken effect.

## Timing
- Req first seen high in IDLE at cycle T:
  - Write: data_write=1 and gnt at T+1.
  - Read: address valid at T+1; rdata/gnt/rvalid at T+2.
- Throughput:
  - Back-to-back writes: one access per 2 cycles.
  - Back-to-back reads: one access per 2 cycles, because the next decision overlaps the read-completion cycle.
- Peripheral requirement: data_out must settle within one cycle of address changing.
- Every output is registered. No combinational path runs from req_* to any output.
- The only combinational input path is data_out to the rdata register.

## Structure
- Package reg_bus_pkg holds:
  - ADDR_W/DATA_W defaults.
  - The FSM state enum (IDLE, WRITE, READ).
  - A helper function for packed-slice indexing.
- Sub-module rr_pick (purely combinational):
  - Inputs: request vector, pointer, exclude mask.
  - Outputs: one-hot winner and any-valid.
  - The arbiter top holds the FSM, pointer, latches and output registers.

## Test plan
- Reset: assert rst for 2 cycles with req=2'b11 → all outputs 0, no data_write; first grant after release goes to requester 0.
- Single write: req0, we=1, addr=4'h3, wdata=8'hA5 → exactly one data_write pulse with address=3 and data_in=A5 at T+1; gnt[0] in the same cycle.
- Single read: peripheral model returns 8'h5A for address 7; req1 read addr=7 → rdata=5A with gnt[1]=rvalid[1]=1 at T+2; rvalid[0] stays 0.
- Contention: req=2'b11 held continuously, both writes → grants alternate 0,1,0,1 over 8 accesses; no requester is starved.
- Reset mid-read: rst pulsed in the READ cycle → no gnt/rvalid, rdata=0; the next request completes normally.
- Stability: req0 changes addr and wdata one cycle after a write is accepted → the peripheral sees only the originally latched values.
